// File: rtl/band_mixer_pkg.sv
// ============================================================================
// band_mixer_pkg : widths, Q-format constants, FSM states and band indices
// Revision 1.0
// ============================================================================
`default_nettype none

package band_mixer_pkg;

  localparam int NUM_BANDS = 10;
  localparam int DATA_W    = 24;
  localparam int GAIN_W    = 16;
  localparam int ACC_W     = DATA_W + GAIN_W + 4;
  localparam int FRAC_BITS = 14;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h4000;

  // Band order as produced by the FIR bank
  localparam int BAND_LP      = 0;
  localparam int BAND_64_125  = 1;
  localparam int BAND_125_250 = 2;
  localparam int BAND_250_500 = 3;
  localparam int BAND_500_1K  = 4;
  localparam int BAND_1K_2K   = 5;
  localparam int BAND_2K_4K   = 6;
  localparam int BAND_4K_8K   = 7;
  localparam int BAND_8K_16K  = 8;
  localparam int BAND_HP      = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2
  } mix_state_t;

endpackage

`default_nettype wire

// File: rtl/band_mixer_round_sat.sv
// ============================================================================
// band_mixer_round_sat : Q-shift with round-half-up and saturation to DATA_W
// Revision 1.0
// ============================================================================
`default_nettype none

module band_mixer_round_sat
  import band_mixer_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] sample,
  output logic                     sat
);

  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1) <<< (FRAC_BITS - 1);
  localparam logic [DATA_W-1:0]       SAT_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]       SAT_MIN    = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] rounded;
  logic                    in_range;

  assign biased  = acc + ROUND_HALF;
  assign rounded = biased >>> FRAC_BITS;

  // Representable iff every bit from the DATA_W sign bit upward agrees
  assign in_range = (&rounded[ACC_W-1:DATA_W-1]) | ~(|rounded[ACC_W-1:DATA_W-1]);

  assign sat    = ~in_range;
  assign sample = in_range          ? rounded[DATA_W-1:0] :
                  rounded[ACC_W-1]  ? SAT_MIN : SAT_MAX;

endmodule

`default_nettype wire

// File: rtl/band_gain_mixer.sv
// ============================================================================
// band_gain_mixer : per-band gain, time-multiplexed MAC, round/saturate mix
// Revision 1.0   optional clip counter: BAND_MIXER_CLIP_CNT_EN
// ============================================================================
`default_nettype none

module band_gain_mixer
  import band_mixer_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        sample_valid,
  input  logic [NUM_BANDS*DATA_W-1:0] bands_in,
  input  logic                        gain_we,
  input  logic [3:0]                  gain_addr,
  input  logic [GAIN_W-1:0]           gain_wdata,
  input  logic                        overrun_clr,
  output logic [DATA_W-1:0]           audio_out,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        overrun,
  output logic [15:0]                 clip_count
);

  localparam int IDX_W  = 4;
  localparam int PROD_W = DATA_W + GAIN_W;

  mix_state_t               state, state_nxt;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] band_q      [NUM_BANDS];
  logic signed [GAIN_W-1:0] gain_shadow [NUM_BANDS];
  logic signed [GAIN_W-1:0] gain_active [NUM_BANDS];
  logic signed [DATA_W-1:0] band_sel;
  logic signed [GAIN_W-1:0] gain_sel;
  logic                     accept;
  logic                     in_mac;
  logic                     in_round;
  logic [DATA_W-1:0]        round_sample;
  logic                     round_sat;

  assign accept = (state == IDLE) && sample_valid && enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (idx == IDX_W'(NUM_BANDS)) state_nxt = ROUND;
      ROUND:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    in_mac   = (state == MAC);
    in_round = (state == ROUND);
  end

  generate
    for (genvar i = 0; i < NUM_BANDS; i++) begin : g_band
      logic wr_hit;
      assign wr_hit = gain_we && (gain_addr == IDX_W'(i));

      // Write-then-copy: a write coincident with acceptance lands in the active set
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          gain_shadow[i] <= GAIN_UNITY;
          gain_active[i] <= GAIN_UNITY;
          band_q[i]      <= '0;
        end else begin
          if (wr_hit) gain_shadow[i] <= gain_wdata;
          if (accept) begin
            gain_active[i] <= wr_hit ? gain_wdata : gain_shadow[i];
            band_q[i]      <= bands_in[DATA_W*i +: DATA_W];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    band_sel = '0;
    gain_sel = '0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      if (idx == IDX_W'(i)) begin
        band_sel = band_q[i];
        gain_sel = gain_active[i];
      end
    end
  end

  // Product is registered, so MAC runs NUM_BANDS+1 cycles to drain the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      acc       <= '0;
      prod      <= '0;
      audio_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        idx  <= '0;
        acc  <= '0;
        prod <= '0;
      end else if (in_mac) begin
        idx  <= idx + IDX_W'(1);
        prod <= band_sel * gain_sel;
        if (idx != '0) acc <= acc + ACC_W'(prod);
      end else if (in_round) begin
        audio_out <= round_sample;
        out_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          overrun <= 1'b0;
    else if (sample_valid && busy)       overrun <= 1'b1;
    else if (overrun_clr)                overrun <= 1'b0;
  end

  band_mixer_round_sat u_round_sat (
    .acc    (acc),
    .sample (round_sample),
    .sat    (round_sat)
  );

`ifdef BAND_MIXER_CLIP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      clip_count <= '0;
    else if (in_round && round_sat && (clip_count != 16'hFFFF))
      clip_count <= clip_count + 16'd1;
  end
`else
  logic unused_round_sat;
  assign unused_round_sat = round_sat;
  assign clip_count       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_band_gain_mixer.sv
// ============================================================================
// tb_band_gain_mixer : directed vectors, expected samples queued to a monitor
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_band_gain_mixer;
  import band_mixer_pkg::*;

  localparam int BW = NUM_BANDS * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              sample_valid;
  logic [BW-1:0]     bands_in;
  logic              gain_we;
  logic [3:0]        gain_addr;
  logic [GAIN_W-1:0] gain_wdata;
  logic              overrun_clr;
  logic [DATA_W-1:0] audio_out;
  logic              out_valid;
  logic              busy;
  logic              overrun;
  logic [15:0]       clip_count;

  band_gain_mixer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_valid (sample_valid),
    .bands_in     (bands_in),
    .gain_we      (gain_we),
    .gain_addr    (gain_addr),
    .gain_wdata   (gain_wdata),
    .overrun_clr  (overrun_clr),
    .audio_out    (audio_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun),
    .clip_count   (clip_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    int unsigned       t_acc;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

`ifdef BAND_MIXER_CLIP_CNT_EN
  localparam logic [15:0] EXP_CLIPS = 16'd2;
`else
  localparam logic [15:0] EXP_CLIPS = 16'd0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every out_valid must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_out_valid: got audio_out 0x%0h, expected no output (cycle %0d)",
                 audio_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("audio_out", audio_out, e.data);
        chk("latency", cyc - e.t_acc, 12);
        chk("busy_at_out_valid", busy, 0);
      end
    end
  end

  function automatic logic [BW-1:0] fill(input logic [DATA_W-1:0] v);
    logic [BW-1:0] b;
    for (int i = 0; i < NUM_BANDS; i++) b[DATA_W*i +: DATA_W] = v;
    return b;
  endfunction

  task automatic send(input logic [BW-1:0] b, input logic [DATA_W-1:0] exp);
    @(negedge clk);
    bands_in     = b;
    sample_valid = 1'b1;
    sb.push_back('{exp, cyc + 1});
    @(negedge clk);
    sample_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic write_gain(input logic [3:0] a, input logic [GAIN_W-1:0] g);
    @(negedge clk);
    gain_we    = 1'b1;
    gain_addr  = a;
    gain_wdata = g;
    @(negedge clk);
    gain_we    = 1'b0;
  endtask

  task automatic all_gains(input logic [GAIN_W-1:0] g);
    for (int i = 0; i < NUM_BANDS; i++) write_gain(4'(i), g);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    chk("drain_pending", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] b;

    rst_n = 1'b0; enable = 1'b1; sample_valid = 1'b0; bands_in = '0;
    gain_we = 1'b0; gain_addr = '0; gain_wdata = '0; overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_audio_out", audio_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_clip_count", clip_count, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Unity gains, all bands 0x1000 -> 10 * 0x1000
    send(fill(24'h001000), 24'h00A000);
    drain();
    repeat (3) @(negedge clk);
    chk("audio_out_hold", audio_out, 24'h00A000);
    chk("clip_after_unity", clip_count, 0);

    // Full-scale saturation both ways
    all_gains(16'h7FFF);
    send(fill(24'h7FFFFF), 24'h7FFFFF);
    drain();
    send(fill(24'h800000), 24'h800000);
    drain();
    chk("clip_count", clip_count, EXP_CLIPS);

    // Rounding: only band 3 at 0.5
    all_gains(16'h0000);
    write_gain(4'd3, 16'h2000);
    b = fill(24'h123456); b[DATA_W*3 +: DATA_W] = 24'h000003;
    send(b, 24'h000002);
    drain();
    b[DATA_W*3 +: DATA_W] = 24'hFFFFFD;
    send(b, 24'hFFFFFF);
    drain();

    // Overrun: second strobe five cycles after the first is dropped
    all_gains(GAIN_UNITY);
    for (int i = 0; i < NUM_BANDS; i++) b[DATA_W*i +: DATA_W] = 24'(i * 'h100);
    send(b, 24'h002D00);
    repeat (3) @(negedge clk);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("overrun_set", overrun, 1);
    drain();
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("overrun_cleared", overrun, 0);
    send(b, 24'h002D00);
    sample_valid = 1'b1; overrun_clr = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0; overrun_clr = 1'b0;
    chk("overrun_set_wins", overrun, 1);
    drain();
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;

    // enable low: strobe dropped without raising overrun
    enable = 1'b0; sample_valid = 1'b1;
    @(negedge clk);
    enable = 1'b1; sample_valid = 1'b0;
    chk("disabled_busy", busy, 0);
    chk("disabled_overrun", overrun, 0);
    repeat (15) @(negedge clk);

    // Gain write during busy applies to the next sample; address 12 ignored
    b = fill(24'h000100); b[DATA_W*0 +: DATA_W] = 24'h010000;
    send(b, 24'h010900);
    write_gain(4'd0, 16'h0000);
    write_gain(4'd12, 16'h0000);
    drain();
    send(b, 24'h000900);
    drain();

    // Write coincident with acceptance is part of that sample's gains
    @(negedge clk);
    bands_in = b; sample_valid = 1'b1;
    gain_we = 1'b1; gain_addr = 4'd1; gain_wdata = 16'h0000;
    sb.push_back('{24'h000800, cyc + 1});
    @(negedge clk);
    sample_valid = 1'b0; gain_we = 1'b0;
    drain();

    // Reset mid-MAC discards the mix and restores unity gains
    send(b, 24'h000800);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_audio_out", audio_out, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_clip_count", clip_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    send(b, 24'h010900);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/band_gain_mixer.md
Name: band_gain_mixer

Overview:
- Downstream of the 10-band FIR bank; consumes the lowpass, eight band-pass and highpass outputs.
- Applies a per-band signed gain and sums the ten products.
- Rounds and saturates the sum to one 24-bit equalized sample.
- A single time-multiplexed MAC serves all bands; the gain register file is double-buffered so gain updates never corrupt an in-flight sum.

Parameters:
- NUM_BANDS, 10, number of band inputs; index 0 = lowpass, 1..8 = 64–125 Hz … 8–16 kHz, 9 = highpass
- DATA_W, 24, sample width (signed)
- GAIN_W, 16, gain width, signed Q2.14 (0x4000 = unity, range -2.0..+1.99994)
- ACC_W, 44, accumulator width = DATA_W+GAIN_W+4

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  global enable; when low, new samples are not accepted
- sample_valid  in  1  one-cycle strobe: bands_in holds a new set of band samples
- bands_in  in  NUM_BANDS*DATA_W  band i occupies bits [DATA_W*i +: DATA_W], signed
- gain_we  in  1  gain write strobe
- gain_addr  in  4  band index for the write
- gain_wdata  in  GAIN_W  signed Q2.14 gain
- overrun_clr  in  1  clears overrun
- audio_out  out  DATA_W  mixed, rounded, saturated sample (signed)
- out_valid  out  1  one-cycle pulse, audio_out updated
- busy  out  1  high while a mix is in progress
- overrun  out  1  sticky: a sample_valid was dropped
- clip_count  out  16  saturation event counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - outputs: audio_out=0, out_valid=0, busy=0, overrun=0, clip_count=0
  - FSM goes to IDLE; accumulator and index are cleared
  - all shadow and active gains = 0x4000
- Gain writes:
  - The write is taken when gain_we=1; the word goes into the shadow register gain_addr.
  - gain_addr >= NUM_BANDS: write ignored.
  - Shadow registers are copied to the active set only on sample acceptance, so a write during busy takes effect on the next sample.
  - A write on the same cycle as acceptance is included in that copy (write-then-copy).
- FSM: IDLE -> MAC -> ROUND -> IDLE.
  - IDLE: accept when sample_valid & enable.
    - Latch all bands_in and copy the gains.
    - acc=0, idx=0, busy=1, go to MAC.
  - MAC: one cycle per band.
    - acc += sext(band[idx]) * gain[idx]; idx++.
    - After idx=NUM_BANDS-1, go to ROUND.
  - ROUND:
    - r = (acc + 2^13) >>> 14 (arithmetic, round half up).
    - Saturate r to [-2^23, 2^23-1] and register it into audio_out.
    - out_valid=1 for one cycle, busy=0, go to IDLE.
- Latency:
  - out_valid is visible exactly NUM_BANDS+2 clock edges after the edge that accepted sample_valid (12 by default).
  - A new sample_valid is acceptable in the same cycle out_valid is high; throughput is 1 sample per 12 clocks.
- audio_out holds its value between out_valid pulses.
- sample_valid while busy, or sample_valid with enable=0:
  - Sample dropped, no state change.
  - overrun is set only in the busy case.
- overrun_clr and a new overrun on the same cycle: set wins.
- enable falling mid-mix: the current mix completes normally.

Optional Feature:
- Macro: BAND_MIXER_CLIP_CNT_EN.
- Defined:
  - clip_count increments on each ROUND in which saturation occurred (either direction).
  - It saturates at 0xFFFF and is cleared only by reset.
- Undefined:
  - clip_count is tied to 0 and no counter logic is built.
  - All other behaviour is identical.

Decomposition:
- Shared package band_mixer_pkg holds:
  - NUM_BANDS, DATA_W, GAIN_W, ACC_W
  - GAIN_UNITY=16'h4000 and the Q-format shift FRAC_BITS=14
  - the FSM state enum (IDLE, MAC, ROUND)
  - band index names matching the filter bank order
- One natural sub-module: band_mixer_round_sat.
  - Combinational: accumulator in, rounded/saturated DATA_W value plus sat flag out.
  - Reused by later output stages.

Test Plan:
- Unity gains, all bands = 0x001000, one sample_valid -> out_valid 12 edges later, audio_out = 0x00A000, busy high for 12 cycles.
- All bands 0x7FFFFF, all gains 0x7FFF -> audio_out = 0x7FFFFF; all bands 0x800000 -> 0x800000; with BAND_MIXER_CLIP_CNT_EN clip_count = 2, without it clip_count = 0.
- Rounding, gains 0 except band 3 = 0x2000:
  - band3 = 0x000003 -> audio_out = 0x000002
  - band3 = 0xFFFFFD (-3) -> audio_out = 0xFFFFFF (-1)
- Second sample_valid 5 cycles after the first -> dropped, single out_valid, overrun = 1; overrun_clr -> 0; overrun_clr together with a new overrun -> stays 1.
- Gain write band 0 = 0x0000 while busy -> current result uses unity; the next sample excludes band 0. Write to gain_addr = 12 -> no effect.
- rst_n pulsed low mid-MAC -> outputs 0 immediately, no out_valid; the next sample after release mixes with unity gains and matches the expected value.
